blinky_start_seq: RTL

- Start-up sequencer that sits directly upstream of the blinky LED counter.
- Synchronises the asynchronous PLL_LOCK_0 (from PF_CCC_C0) and DEVICE_INIT_DONE (from PFSOC_INIT_MONITOR_C0) into the fabric clock domain.
- Holds blinky disabled and in reset until both are valid and the PLL has stayed locked for a qualification period.
- Drops enable on lock loss, counts faults, and retries after a hold-off.

---
 rtl/blinky_start_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/blinky_start_seq.sv
// Start-up sequencer: holds blinky in reset until PLL lock and device init are stable; drops on lock loss.
// Latency: enable after SYNC_STAGES+LOCK_STABLE_CYCLES edges, lock loss seen in SYNC_STAGES+1; no backpressure.
module blinky_start_seq #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES     = 256,
    parameter int CNT_W              = 16,
    parameter int SYNC_STAGES        = 2
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       device_init_done,
    output logic       enable,
    output logic       blinky_rst,
    output logic [7:0] fault_count,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WAIT_LOCK = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [7:0]             fault_nxt;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] init_sync;
    logic                   lock_s;
    logic                   init_s;

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign init_s = init_sync[SYNC_STAGES-1];

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_sync <= '0;
            init_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
            init_sync <= {init_sync[SYNC_STAGES-2:0], device_init_done};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fault_nxt = fault_count;
        case (state)
            IDLE: state_nxt = WAIT_INIT;
            WAIT_INIT: begin
                if (init_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (!init_s) begin
                    state_nxt = WAIT_INIT;
                end else if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                // Init loss is a controlled shutdown, not a lock fault.
                if (!init_s) begin
                    state_nxt = WAIT_INIT;
                end else if (!lock_s) begin
                    state_nxt = FAULT;
                    cnt_nxt   = '0;
                    if (fault_count != 8'hFF) begin
                        fault_nxt = fault_count + 8'd1;
                    end
                end
            end
            FAULT: begin
                if (!init_s) begin
                    state_nxt = WAIT_INIT;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            fault_count <= 8'd0;
            enable      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            fault_count <= fault_nxt;
            enable      <= (state_nxt == RUN);
        end
    end

    assign blinky_rst = ~enable;
    assign seq_state  = state;

endmodule
